// File: rtl/uart_cmd_responder_pkg.sv
// Shared types and constants for the UART command responder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT, GET_CMD, GET_ARG, GET_CHK, SEND0, WAIT_HI, WAIT_LO, SEND1
  } state_t;

  localparam logic [7:0] SYNC_DEF    = 8'hAA;
  localparam logic [7:0] ACK_DEF     = 8'h06;
  localparam logic [7:0] NAK_DEF     = 8'h15;
  localparam int         TIMEOUT_DEF = 2500000;

  // A counter of clog2(N) bits is enough to reach N-1.
  function automatic int tmr_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int TMR_W_DEF = tmr_width(TIMEOUT_DEF);

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts while enabled and parks at the last value.
module uart_frame_timer import uart_cmd_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk_50m,
  input  logic clear_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            W    = tmr_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_50m) begin
    if (!clear_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Frames SYNC/CMD/ARG/CHK commands from the UART receiver, publishes valid
// commands and answers the host with a two-byte ACK/NAK reply.
module uart_cmd_responder import uart_cmd_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEF,
  parameter logic [7:0] ACK_BYTE       = ACK_DEF,
  parameter logic [7:0] NAK_BYTE       = NAK_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int         BUSY_GUARD     = 4
) (
  input  logic       clk_50m,
  input  logic       clear_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_ready_clr,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  input  logic       tx_busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic [7:0] err_cnt
);

  localparam int GW = $clog2(BUSY_GUARD + 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_r_q, cmd_r_d, arg_r_q, arg_r_d, reply0_q, reply0_d;
  logic [7:0]  tx_data_q, tx_data_d, cmd_code_q, cmd_code_d;
  logic [7:0]  cmd_arg_q, cmd_arg_d, err_cnt_q, err_cnt_d;
  logic        rx_ready_clr_q, rx_ready_clr_d, tx_wr_en_q, tx_wr_en_d;
  logic        cmd_valid_q, cmd_valid_d, second_q, second_d;
  logic [GW-1:0] guard_q, guard_d;
  logic        in_frame, take, expired;
  logic [7:0]  err_inc;

  assign in_frame = state_q inside {GET_CMD, GET_ARG, GET_CHK};
  // The registered clear is still high while the receiver drops rx_ready.
  assign take     = (in_frame || state_q == HUNT) && rx_ready && !rx_ready_clr_q;
  assign err_inc  = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  uart_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_50m (clk_50m),
    .clear_n (clear_n),
    .clr     (take || !in_frame),
    .en      (in_frame),
    .expired (expired)
  );

  always_comb begin
    state_d        = state_q;
    cmd_r_d        = cmd_r_q;
    arg_r_d        = arg_r_q;
    reply0_d       = reply0_q;
    tx_data_d      = tx_data_q;
    cmd_code_d     = cmd_code_q;
    cmd_arg_d      = cmd_arg_q;
    err_cnt_d      = err_cnt_q;
    second_d       = second_q;
    guard_d        = guard_q;
    rx_ready_clr_d = take;
    tx_wr_en_d     = 1'b0;
    cmd_valid_d    = 1'b0;
    case (state_q)
      HUNT: if (take && rx_data == SYNC_BYTE) state_d = GET_CMD;
      GET_CMD: begin
        if (take) begin
          if (rx_data != SYNC_BYTE) begin
            cmd_r_d = rx_data;
            state_d = GET_ARG;
          end
        end else if (expired) begin
          state_d   = HUNT;
          err_cnt_d = err_inc;
        end
      end
      GET_ARG: begin
        if (take) begin
          arg_r_d = rx_data;
          state_d = GET_CHK;
        end else if (expired) begin
          state_d   = HUNT;
          err_cnt_d = err_inc;
        end
      end
      GET_CHK: begin
        if (take) begin
          if (rx_data == (cmd_r_q ^ arg_r_q)) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = cmd_r_q;
            cmd_arg_d   = arg_r_q;
            reply0_d    = ACK_BYTE;
          end else begin
            reply0_d  = NAK_BYTE;
            err_cnt_d = err_inc;
          end
          second_d = 1'b0;
          state_d  = SEND0;
        end else if (expired) begin
          state_d   = HUNT;
          err_cnt_d = err_inc;
        end
      end
      SEND0, SEND1: begin
        if (!tx_busy) begin
          tx_data_d  = (state_q == SEND0) ? reply0_q : cmd_r_q;
          tx_wr_en_d = 1'b1;
          second_d   = (state_q == SEND1);
          guard_d    = '0;
          state_d    = WAIT_HI;
        end
      end
      // A transmitter that never raises busy must not stall the reply.
      WAIT_HI: begin
        if (tx_busy || guard_q == GW'(BUSY_GUARD - 1)) state_d = WAIT_LO;
        else                                            guard_d = guard_q + GW'(1);
      end
      WAIT_LO: if (!tx_busy) state_d = second_q ? HUNT : SEND1;
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!clear_n) begin
      state_q        <= HUNT;
      cmd_r_q        <= '0;
      arg_r_q        <= '0;
      reply0_q       <= '0;
      tx_data_q      <= '0;
      cmd_code_q     <= '0;
      cmd_arg_q      <= '0;
      err_cnt_q      <= '0;
      second_q       <= 1'b0;
      guard_q        <= '0;
      rx_ready_clr_q <= 1'b0;
      tx_wr_en_q     <= 1'b0;
      cmd_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_r_q        <= cmd_r_d;
      arg_r_q        <= arg_r_d;
      reply0_q       <= reply0_d;
      tx_data_q      <= tx_data_d;
      cmd_code_q     <= cmd_code_d;
      cmd_arg_q      <= cmd_arg_d;
      err_cnt_q      <= err_cnt_d;
      second_q       <= second_d;
      guard_q        <= guard_d;
      rx_ready_clr_q <= rx_ready_clr_d;
      tx_wr_en_q     <= tx_wr_en_d;
      cmd_valid_q    <= cmd_valid_d;
    end
  end

  assign rx_ready_clr = rx_ready_clr_q;
  assign tx_data      = tx_data_q;
  assign tx_wr_en     = tx_wr_en_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign cmd_arg      = cmd_arg_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench: receiver/transmitter models around the responder, hand-computed expectations.
module tb_uart_cmd_responder;

  logic       clk_50m = 1'b0;
  logic       clear_n;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_ready_clr;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_busy;
  logic       cmd_valid;
  logic [7:0] cmd_code, cmd_arg, err_cnt;

  uart_cmd_responder #(.TIMEOUT_CYCLES(100), .BUSY_GUARD(4)) dut (
    .clk_50m      (clk_50m),
    .clear_n      (clear_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .tx_data      (tx_data),
    .tx_wr_en     (tx_wr_en),
    .tx_busy      (tx_busy),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_arg      (cmd_arg),
    .err_cnt      (err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  // transmitter model and event logs
  int         cyc = 0;
  int         busy_cnt = 0;
  int         busy_len;
  logic       no_busy;
  logic [7:0] tx_log[$];
  int         tx_t[$];
  int         vcnt = 0;
  int         wr_busy = 0;

  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk_50m) begin
    cyc <= cyc + 1;
    if (cmd_valid) vcnt <= vcnt + 1;
    if (tx_wr_en && tx_busy) wr_busy <= wr_busy + 1;
    if (tx_wr_en) begin
      tx_log.push_back(tx_data);
      tx_t.push_back(cyc);
      busy_cnt <= no_busy ? 0 : busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int i;
    @(negedge clk_50m);
    rx_data  = b;
    rx_ready = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk_50m);
      if (rx_ready_clr) break;
    end
    if (i == 200) chk("rx_consume_tmo", 32'd0, 32'd1);
    rx_ready = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, b, c, d);
    send_byte(a); send_byte(b); send_byte(c); send_byte(d);
  endtask

  task automatic wait_reply(input string tag, input int n);
    for (int i = 0; i < 400 && tx_log.size() < n; i++) @(negedge clk_50m);
    chk(tag, tx_log.size(), n);
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk_50m);
    repeat (3) @(negedge clk_50m);
  endtask

  task automatic do_reset();
    @(negedge clk_50m); clear_n = 1'b0;
    @(negedge clk_50m); clear_n = 1'b1;
  endtask

  int k, v0, w0;

  initial begin
    clear_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    busy_len = 10; no_busy = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("rst_clr",   rx_ready_clr, 0);
    chk("rst_wr",    tx_wr_en, 0);
    chk("rst_txd",   tx_data, 0);
    chk("rst_vld",   cmd_valid, 0);
    chk("rst_code",  cmd_code, 0);
    chk("rst_arg",   cmd_arg, 0);
    chk("rst_err",   err_cnt, 0);
    clear_n = 1'b1;

    // good frame
    k = tx_log.size(); v0 = vcnt;
    send4(8'hAA, 8'h01, 8'h7F, 8'h7E);
    wait_reply("f1_nwr", k + 2);
    chk("f1_vld",  vcnt - v0, 1);
    chk("f1_code", cmd_code, 8'h01);
    chk("f1_arg",  cmd_arg, 8'h7F);
    chk("f1_tx0",  tx_log[k], 8'h06);
    chk("f1_tx1",  tx_log[k+1], 8'h01);
    chk("f1_err",  err_cnt, 0);
    chk("f1_gap",  tx_t[k+1] - tx_t[k], 13);

    // bad checksum
    k = tx_log.size(); v0 = vcnt;
    send4(8'hAA, 8'h01, 8'h7F, 8'h00);
    wait_reply("f2_nwr", k + 2);
    chk("f2_vld",  vcnt - v0, 0);
    chk("f2_code", cmd_code, 8'h01);
    chk("f2_arg",  cmd_arg, 8'h7F);
    chk("f2_tx0",  tx_log[k], 8'h15);
    chk("f2_tx1",  tx_log[k+1], 8'h01);
    chk("f2_err",  err_cnt, 1);

    // junk byte dropped, double sync resyncs
    k = tx_log.size(); v0 = vcnt;
    send_byte(8'h55); send_byte(8'hAA);
    send4(8'hAA, 8'h02, 8'h03, 8'h01);
    wait_reply("f3_nwr", k + 2);
    chk("f3_vld",  vcnt - v0, 1);
    chk("f3_code", cmd_code, 8'h02);
    chk("f3_arg",  cmd_arg, 8'h03);
    chk("f3_tx0",  tx_log[k], 8'h06);
    chk("f3_tx1",  tx_log[k+1], 8'h02);
    chk("f3_err",  err_cnt, 1);

    // inter-byte timeout
    do_reset();
    k = tx_log.size();
    send_byte(8'hAA); send_byte(8'h01);
    repeat (50) @(negedge clk_50m);
    chk("to_early_err", err_cnt, 0);
    repeat (100) @(negedge clk_50m);
    chk("to_err",  err_cnt, 1);
    chk("to_nwr",  tx_log.size(), k);
    v0 = vcnt;
    send4(8'hAA, 8'h04, 8'h05, 8'h01);
    wait_reply("to_f_nwr", k + 2);
    chk("to_f_vld",  vcnt - v0, 1);
    chk("to_f_code", cmd_code, 8'h04);
    chk("to_f_arg",  cmd_arg, 8'h05);
    chk("to_f_tx0",  tx_log[k], 8'h06);
    chk("to_f_tx1",  tx_log[k+1], 8'h04);

    // long busy: second write waits for busy to fall
    busy_len = 20; k = tx_log.size(); w0 = wr_busy;
    send4(8'hAA, 8'h10, 8'h20, 8'h30);
    wait_reply("b20_nwr", k + 2);
    chk("b20_gap",  tx_t[k+1] - tx_t[k], 23);
    chk("b20_wrbz", wr_busy - w0, 0);

    // busy never rises: guard releases after 4 cycles
    no_busy = 1'b1; k = tx_log.size();
    send4(8'hAA, 8'h11, 8'h22, 8'h33);
    wait_reply("nb_nwr", k + 2);
    chk("nb_gap", tx_t[k+1] - tx_t[k], 6);
    chk("nb_tx1", tx_log[k+1], 8'h11);
    no_busy = 1'b0;

    // reset while waiting for the first reply byte to finish
    k = tx_log.size();
    send4(8'hAA, 8'h01, 8'h02, 8'h03);
    for (int i = 0; i < 50 && tx_log.size() < k + 1; i++) @(negedge clk_50m);
    repeat (5) @(negedge clk_50m);
    clear_n = 1'b0;
    @(negedge clk_50m);
    chk("mr_wr",   tx_wr_en, 0);
    chk("mr_txd",  tx_data, 0);
    chk("mr_code", cmd_code, 0);
    chk("mr_arg",  cmd_arg, 0);
    chk("mr_err",  err_cnt, 0);
    clear_n = 1'b1;
    repeat (60) @(negedge clk_50m);
    chk("mr_nwr", tx_log.size(), k + 1);

    // error counter saturation
    busy_len = 2;
    for (int f = 0; f < 256; f++) send4(8'hAA, 8'h00, 8'h00, 8'h01);
    k = tx_log.size();
    wait_reply("sat_nwr", k + 1);
    chk("sat_err", err_cnt, 8'hFF);
    chk("sat_tx0", tx_log[tx_log.size()-2], 8'h15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
